// File: rtl/ex_stage_unit.sv
// ex_stage_unit -- ID/EX slice of the 5-stage MIPS pipeline.
//
// Decodes the ID instruction into main control. Latches operands and control
// into the ID/EX register on the falling clock edge. In EX it selects the
// forwarded operands (MEM before WB) and runs the ALU.
//
// Ports:
//   clk, rst                    falling-edge ID/EX register, async active-high reset
//   instr_d, ctrl_en            ID instruction; ctrl_en=0 inserts a bubble
//   rs_d, rt_d, imm_d, pc_d     register data, sign-extended immediate, PC+4
//   reg_write_m/_w, write_reg_addr_m/_w, alu_out_m, write_result_w
//                               MEM / WB forwarding sources
//   *_d                         combinational ID decode (branch/jump/link/jr, target)
//   *_e                         EX results and registered control for EX/MEM
//
// Build option: define EX_OVERFLOW_EN to add ovf_e. It flags signed overflow
// of add/sub/addi and does not change the result or the writeback.
module ex_stage_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     instr_d,
    input  logic            ctrl_en,
    input  logic [XLEN-1:0] rs_d,
    input  logic [XLEN-1:0] rt_d,
    input  logic [XLEN-1:0] imm_d,
    input  logic [XLEN-1:0] pc_d,
    input  logic            reg_write_m,
    input  logic [4:0]      write_reg_addr_m,
    input  logic [XLEN-1:0] alu_out_m,
    input  logic            reg_write_w,
    input  logic [4:0]      write_reg_addr_w,
    input  logic [XLEN-1:0] write_result_w,
    output logic            reg_write_d,
    output logic            mem_to_reg_d,
    output logic            mem_read_d,
    output logic            mem_write_d,
    output logic            branch_d,
    output logic            branch_eq_d,
    output logic            jump_d,
    output logic            link_d,
    output logic            jr_d,
    output logic [25:0]     target_d,
    output logic            reg_write_e,
    output logic            mem_to_reg_e,
    output logic            mem_read_e,
    output logic            mem_write_e,
    output logic [4:0]      rt_addr_e,
    output logic [XLEN-1:0] alu_out_e,
    output logic [XLEN-1:0] write_data_e,
    output logic [4:0]      write_reg_addr_e,
    output logic            zero_e,
`ifdef EX_OVERFLOW_EN
    output logic            ovf_e,
`endif
    output logic [XLEN-1:0] pc_branch_e
);

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3,
        ALU_XOR = 4'd4, ALU_NOR = 4'd5, ALU_SLT = 4'd6, ALU_SLL = 4'd7,
        ALU_SRL = 4'd8, ALU_SRA = 4'd9
    } alu_op_t;

    typedef enum logic [1:0] {B_RT, B_SEXT, B_ZEXT} b_sel_t;
    typedef enum logic [1:0] {DST_RD, DST_RT, DST_RA} dst_sel_t;

    // ---------------- ID decode ----------------
    logic [5:0] w_op, w_fn;
    logic       w_reg_write, w_mem_to_reg, w_mem_read, w_mem_write;
    logic       w_branch, w_branch_eq, w_jump, w_link, w_jr, w_shamt_sel;
    alu_op_t    w_alu;
    b_sel_t     w_b_sel;
    dst_sel_t   w_dst_sel;
    logic [4:0] w_dst;

    assign w_op = instr_d[31:26];
    assign w_fn = instr_d[5:0];

    always_comb begin
        w_reg_write = 1'b0; w_mem_to_reg = 1'b0; w_mem_read = 1'b0;
        w_mem_write = 1'b0; w_branch = 1'b0; w_branch_eq = 1'b0;
        w_jump = 1'b0; w_link = 1'b0; w_jr = 1'b0; w_shamt_sel = 1'b0;
        w_alu = ALU_ADD; w_b_sel = B_RT; w_dst_sel = DST_RD;
        if (ctrl_en) begin
            case (w_op)
                6'h00: if (instr_d != '0) begin
                    w_reg_write = 1'b1;
                    case (w_fn)
                        6'h20, 6'h21: w_alu = ALU_ADD;
                        6'h22, 6'h23: w_alu = ALU_SUB;
                        6'h24: w_alu = ALU_AND;
                        6'h25: w_alu = ALU_OR;
                        6'h26: w_alu = ALU_XOR;
                        6'h27: w_alu = ALU_NOR;
                        6'h2A: w_alu = ALU_SLT;
                        6'h00: begin w_alu = ALU_SLL; w_shamt_sel = 1'b1; end
                        6'h02: begin w_alu = ALU_SRL; w_shamt_sel = 1'b1; end
                        6'h03: begin w_alu = ALU_SRA; w_shamt_sel = 1'b1; end
                        6'h04: w_alu = ALU_SLL;
                        6'h06: w_alu = ALU_SRL;
                        6'h07: w_alu = ALU_SRA;
                        6'h08: begin w_reg_write = 1'b0; w_jump = 1'b1; w_jr = 1'b1; end
                        default: w_reg_write = 1'b0;
                    endcase
                end
                6'h08, 6'h09: begin w_reg_write = 1'b1; w_b_sel = B_SEXT; w_dst_sel = DST_RT; end
                6'h0C: begin w_reg_write = 1'b1; w_alu = ALU_AND; w_b_sel = B_ZEXT; w_dst_sel = DST_RT; end
                6'h0D: begin w_reg_write = 1'b1; w_alu = ALU_OR;  w_b_sel = B_ZEXT; w_dst_sel = DST_RT; end
                6'h0E: begin w_reg_write = 1'b1; w_alu = ALU_XOR; w_b_sel = B_ZEXT; w_dst_sel = DST_RT; end
                6'h04: begin w_branch = 1'b1; w_branch_eq = 1'b1; w_alu = ALU_SUB; end
                6'h05: begin w_branch = 1'b1; w_alu = ALU_SUB; end
                6'h23: begin
                    w_reg_write = 1'b1; w_mem_to_reg = 1'b1; w_mem_read = 1'b1;
                    w_b_sel = B_SEXT; w_dst_sel = DST_RT;
                end
                6'h2B: begin w_mem_write = 1'b1; w_b_sel = B_SEXT; end
                6'h02: w_jump = 1'b1;
                6'h03: begin w_jump = 1'b1; w_link = 1'b1; w_reg_write = 1'b1; w_dst_sel = DST_RA; end
                default: ;
            endcase
        end
    end

    always_comb begin
        case (w_dst_sel)
            DST_RT:  w_dst = instr_d[20:16];
            DST_RA:  w_dst = 5'd31;
            default: w_dst = instr_d[15:11];
        endcase
    end

    assign reg_write_d  = w_reg_write;
    assign mem_to_reg_d = w_mem_to_reg;
    assign mem_read_d   = w_mem_read;
    assign mem_write_d  = w_mem_write;
    assign branch_d     = w_branch;
    assign branch_eq_d  = w_branch_eq;
    assign jump_d       = w_jump;
    assign link_d       = w_link;
    assign jr_d         = w_jr;
    assign target_d     = instr_d[25:0];

    // ---------------- ID/EX register ----------------
    logic            r_reg_write, r_mem_to_reg, r_mem_read, r_mem_write, r_link, r_shamt_sel;
    alu_op_t         r_alu;
    b_sel_t          r_b_sel;
    logic [4:0]      r_rs_addr, r_rt_addr, r_dst, r_shamt;
    logic [XLEN-1:0] r_rs, r_rt, r_imm, r_pc;

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            r_reg_write <= 1'b0; r_mem_to_reg <= 1'b0; r_mem_read <= 1'b0;
            r_mem_write <= 1'b0; r_link <= 1'b0; r_shamt_sel <= 1'b0;
            r_alu <= ALU_ADD; r_b_sel <= B_RT;
            r_rs_addr <= '0; r_rt_addr <= '0; r_dst <= '0; r_shamt <= '0;
            r_rs <= '0; r_rt <= '0; r_imm <= '0; r_pc <= '0;
        end else begin
            r_reg_write <= w_reg_write; r_mem_to_reg <= w_mem_to_reg;
            r_mem_read <= w_mem_read; r_mem_write <= w_mem_write;
            r_link <= w_link; r_shamt_sel <= w_shamt_sel;
            r_alu <= w_alu; r_b_sel <= w_b_sel;
            r_rs_addr <= instr_d[25:21]; r_rt_addr <= instr_d[20:16];
            r_dst <= w_dst; r_shamt <= instr_d[10:6];
            r_rs <= rs_d; r_rt <= rt_d; r_imm <= imm_d; r_pc <= pc_d;
        end
    end

    // ---------------- EX: forwarding and ALU ----------------
    logic            w_fwd_m_a, w_fwd_w_a, w_fwd_m_b, w_fwd_w_b;
    logic [XLEN-1:0] w_fwd_a, w_fwd_b, w_op_a, w_op_b, w_alu_res;
    logic [4:0]      w_sh;

    assign w_fwd_m_a = reg_write_m && (write_reg_addr_m != 5'd0) && (write_reg_addr_m == r_rs_addr);
    assign w_fwd_w_a = reg_write_w && (write_reg_addr_w != 5'd0) && (write_reg_addr_w == r_rs_addr);
    assign w_fwd_m_b = reg_write_m && (write_reg_addr_m != 5'd0) && (write_reg_addr_m == r_rt_addr);
    assign w_fwd_w_b = reg_write_w && (write_reg_addr_w != 5'd0) && (write_reg_addr_w == r_rt_addr);

    assign w_fwd_a = w_fwd_m_a ? alu_out_m : (w_fwd_w_a ? write_result_w : r_rs);
    assign w_fwd_b = w_fwd_m_b ? alu_out_m : (w_fwd_w_b ? write_result_w : r_rt);

    assign w_op_a = r_shamt_sel ? {{(XLEN-5){1'b0}}, r_shamt} : w_fwd_a;

    always_comb begin
        case (r_b_sel)
            B_SEXT:  w_op_b = r_imm;
            B_ZEXT:  w_op_b = {{(XLEN-16){1'b0}}, r_imm[15:0]};
            default: w_op_b = w_fwd_b;
        endcase
    end

    assign w_sh = w_op_a[4:0];

    always_comb begin
        case (r_alu)
            ALU_SUB: w_alu_res = w_op_a - w_op_b;
            ALU_AND: w_alu_res = w_op_a & w_op_b;
            ALU_OR:  w_alu_res = w_op_a | w_op_b;
            ALU_XOR: w_alu_res = w_op_a ^ w_op_b;
            ALU_NOR: w_alu_res = ~(w_op_a | w_op_b);
            ALU_SLT: w_alu_res = {{(XLEN-1){1'b0}}, ($signed(w_op_a) < $signed(w_op_b))};
            ALU_SLL: w_alu_res = w_op_b << w_sh;
            ALU_SRL: w_alu_res = w_op_b >> w_sh;
            ALU_SRA: w_alu_res = $unsigned($signed(w_op_b) >>> w_sh);
            default: w_alu_res = w_op_a + w_op_b;
        endcase
    end

    assign alu_out_e        = r_link ? r_pc : w_alu_res;
    assign zero_e           = (w_alu_res == '0);
    assign write_data_e     = w_fwd_b;
    assign write_reg_addr_e = r_dst;
    assign rt_addr_e        = r_rt_addr;
    assign pc_branch_e      = r_pc + {r_imm[XLEN-3:0], 2'b00};
    assign reg_write_e      = r_reg_write;
    assign mem_to_reg_e     = r_mem_to_reg;
    assign mem_read_e       = r_mem_read;
    assign mem_write_e      = r_mem_write;

`ifdef EX_OVERFLOW_EN
    // Only add/sub/addi trap-class ops flag overflow; unsigned variants never do.
    logic w_ovf_chk, r_ovf_chk;
    assign w_ovf_chk = ctrl_en && ((w_op == 6'h00 && (w_fn == 6'h20 || w_fn == 6'h22)) || w_op == 6'h08);

    always_ff @(negedge clk or posedge rst) begin
        if (rst) r_ovf_chk <= 1'b0;
        else     r_ovf_chk <= w_ovf_chk;
    end

    always_comb begin
        ovf_e = 1'b0;
        if (r_ovf_chk) begin
            if (r_alu == ALU_SUB)
                ovf_e = (w_op_a[XLEN-1] != w_op_b[XLEN-1]) && (w_alu_res[XLEN-1] != w_op_a[XLEN-1]);
            else
                ovf_e = (w_op_a[XLEN-1] == w_op_b[XLEN-1]) && (w_alu_res[XLEN-1] != w_op_a[XLEN-1]);
        end
    end
`endif

endmodule

// File: tb/tb_ex_stage_unit.sv
// Directed testbench for ex_stage_unit. Inputs change just after a falling
// edge; EX outputs are sampled 1 time unit after the falling edge that loads.
module tb_ex_stage_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr_d = '0;
    logic        ctrl_en = 1'b1;
    logic [31:0] rs_d = '0, rt_d = '0, imm_d = '0, pc_d = '0;
    logic        reg_write_m = 1'b0, reg_write_w = 1'b0;
    logic [4:0]  write_reg_addr_m = '0, write_reg_addr_w = '0;
    logic [31:0] alu_out_m = '0, write_result_w = '0;
    logic        reg_write_d, mem_to_reg_d, mem_read_d, mem_write_d;
    logic        branch_d, branch_eq_d, jump_d, link_d, jr_d;
    logic [25:0] target_d;
    logic        reg_write_e, mem_to_reg_e, mem_read_e, mem_write_e;
    logic [4:0]  rt_addr_e, write_reg_addr_e;
    logic [31:0] alu_out_e, write_data_e, pc_branch_e;
    logic        zero_e;
`ifdef EX_OVERFLOW_EN
    logic        ovf_e;
`endif

    logic [8:0]  dctl;
    logic [3:0]  ectl;
    assign dctl = {reg_write_d, mem_to_reg_d, mem_read_d, mem_write_d,
                   branch_d, branch_eq_d, jump_d, link_d, jr_d};
    assign ectl = {reg_write_e, mem_to_reg_e, mem_read_e, mem_write_e};

    int checks = 0;
    int passed = 0;

    ex_stage_unit #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .instr_d(instr_d), .ctrl_en(ctrl_en),
        .rs_d(rs_d), .rt_d(rt_d), .imm_d(imm_d), .pc_d(pc_d),
        .reg_write_m(reg_write_m), .write_reg_addr_m(write_reg_addr_m), .alu_out_m(alu_out_m),
        .reg_write_w(reg_write_w), .write_reg_addr_w(write_reg_addr_w), .write_result_w(write_result_w),
        .reg_write_d(reg_write_d), .mem_to_reg_d(mem_to_reg_d), .mem_read_d(mem_read_d),
        .mem_write_d(mem_write_d), .branch_d(branch_d), .branch_eq_d(branch_eq_d),
        .jump_d(jump_d), .link_d(link_d), .jr_d(jr_d), .target_d(target_d),
        .reg_write_e(reg_write_e), .mem_to_reg_e(mem_to_reg_e), .mem_read_e(mem_read_e),
        .mem_write_e(mem_write_e), .rt_addr_e(rt_addr_e), .alu_out_e(alu_out_e),
        .write_data_e(write_data_e), .write_reg_addr_e(write_reg_addr_e), .zero_e(zero_e),
`ifdef EX_OVERFLOW_EN
        .ovf_e(ovf_e),
`endif
        .pc_branch_e(pc_branch_e)
    );

    always #5 clk = ~clk;

    task automatic fall();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt,
                         input logic [31:0] imm, input logic [31:0] pc);
        instr_d = ins; rs_d = rs; rt_d = rt; imm_d = imm; pc_d = pc;
        #1;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (ectl !== 4'b0) $display("FAIL rst_ectl: got %b want %b", ectl, 4'b0); else passed++;
        checks++; if (write_reg_addr_e !== 5'd0) $display("FAIL rst_wra: got %0d want 0", write_reg_addr_e); else passed++;
        checks++; if (alu_out_e !== 32'd0) $display("FAIL rst_alu: got %h want 0", alu_out_e); else passed++;
        checks++; if (pc_branch_e !== 32'd0) $display("FAIL rst_pcb: got %h want 0", pc_branch_e); else passed++;
        rst = 1'b0;
    endtask

    task automatic test_alu_rtype();
        drive(32'h00221820, 32'd5, 32'd7, 32'h1820, 32'h0); // add $3,$1,$2
        checks++; if (dctl !== 9'h100) $display("FAIL add_dctl: got %h want %h", dctl, 9'h100); else passed++;
        fall();
        checks++; if (alu_out_e !== 32'd12) $display("FAIL add_alu: got %h want %h", alu_out_e, 32'd12); else passed++;
        checks++; if (write_reg_addr_e !== 5'd3) $display("FAIL add_wra: got %0d want 3", write_reg_addr_e); else passed++;
        checks++; if (ectl !== 4'b1000) $display("FAIL add_ectl: got %b want 1000", ectl); else passed++;
        checks++; if (write_data_e !== 32'd7) $display("FAIL add_wdata: got %h want 7", write_data_e); else passed++;
        checks++; if (zero_e !== 1'b0) $display("FAIL add_zero: got %b want 0", zero_e); else passed++;
        drive(32'h00223022, 32'd3, 32'd5, 32'h0, 32'h0); // sub $6,$1,$2
        fall();
        checks++; if (alu_out_e !== 32'hFFFFFFFE) $display("FAIL sub_wrap: got %h want FFFFFFFE", alu_out_e); else passed++;
        drive(32'h0043082A, 32'hFFFFFFFF, 32'd1, 32'h0, 32'h0); // slt $1,$2,$3
        fall();
        checks++; if (alu_out_e !== 32'd1) $display("FAIL slt_signed: got %h want 1", alu_out_e); else passed++;
        drive(32'h00430827, 32'hF0F0F0F0, 32'h0F0F0000, 32'h0, 32'h0); // nor $1,$2,$3
        fall();
        checks++; if (alu_out_e !== 32'h00000F0F) $display("FAIL nor: got %h want 00000F0F", alu_out_e); else passed++;
    endtask

    task automatic test_forward();
        drive(32'h00802820, 32'd100, 32'd0, 32'h0, 32'h0); // add $5,$4,$0
        fall();
        reg_write_m = 1'b1; write_reg_addr_m = 5'd4; alu_out_m = 32'd9;
        reg_write_w = 1'b1; write_reg_addr_w = 5'd4; write_result_w = 32'd3;
        #1;
        checks++; if (alu_out_e !== 32'd9) $display("FAIL fwd_mem_prio: got %0d want 9", alu_out_e); else passed++;
        reg_write_m = 1'b0; #1;
        checks++; if (alu_out_e !== 32'd3) $display("FAIL fwd_wb: got %0d want 3", alu_out_e); else passed++;
        reg_write_w = 1'b0; #1;
        checks++; if (alu_out_e !== 32'd100) $display("FAIL fwd_none: got %0d want 100", alu_out_e); else passed++;
        reg_write_m = 1'b1; write_reg_addr_m = 5'd0; alu_out_m = 32'd55; #1;
        checks++; if (write_data_e !== 32'd0) $display("FAIL fwd_r0: got %0d want 0", write_data_e); else passed++;
        checks++; if (alu_out_e !== 32'd100) $display("FAIL fwd_r0_a: got %0d want 100", alu_out_e); else passed++;
        reg_write_m = 1'b0;
    endtask

    task automatic test_shifts();
        drive(32'h00062903, 32'hFFFFFFFF, 32'h80000000, 32'h0, 32'h0); // sra $5,$6,4
        fall();
        checks++; if (alu_out_e !== 32'hF8000000) $display("FAIL sra: got %h want F8000000", alu_out_e); else passed++;
        drive(32'h01283804, 32'd33, 32'd3, 32'h0, 32'h0); // sllv $7,$8,$9
        fall();
        checks++; if (alu_out_e !== 32'd6) $display("FAIL sllv_mod32: got %h want 6", alu_out_e); else passed++;
        drive(32'h00031202, 32'hFFFFFFFF, 32'h80000000, 32'h0, 32'h0); // srl $2,$3,8
        fall();
        checks++; if (alu_out_e !== 32'h00800000) $display("FAIL srl: got %h want 00800000", alu_out_e); else passed++;
    endtask

    task automatic test_branch();
        drive(32'h1022FFFF, 32'd10, 32'd10, 32'hFFFFFFFF, 32'h100); // beq $1,$2,-1
        checks++; if (dctl !== 9'h018) $display("FAIL beq_dctl: got %h want %h", dctl, 9'h018); else passed++;
        fall();
        checks++; if (zero_e !== 1'b1) $display("FAIL beq_zero: got %b want 1", zero_e); else passed++;
        checks++; if (pc_branch_e !== 32'h000000FC) $display("FAIL beq_pcb: got %h want 000000FC", pc_branch_e); else passed++;
        checks++; if (ectl !== 4'b0) $display("FAIL beq_ectl: got %b want 0000", ectl); else passed++;
        drive(32'h1422FFFF, 32'd10, 32'd11, 32'hFFFFFFFF, 32'h100); // bne
        checks++; if (dctl !== 9'h010) $display("FAIL bne_dctl: got %h want %h", dctl, 9'h010); else passed++;
        fall();
        checks++; if (zero_e !== 1'b0) $display("FAIL bne_zero: got %b want 0", zero_e); else passed++;
    endtask

    task automatic test_jump();
        drive(32'h0C000040, 32'd1, 32'd2, 32'h40, 32'h20); // jal 0x40
        checks++; if (dctl !== 9'h106) $display("FAIL jal_dctl: got %h want %h", dctl, 9'h106); else passed++;
        checks++; if (target_d !== 26'h40) $display("FAIL jal_target: got %h want 40", target_d); else passed++;
        fall();
        checks++; if (write_reg_addr_e !== 5'd31) $display("FAIL jal_wra: got %0d want 31", write_reg_addr_e); else passed++;
        checks++; if (alu_out_e !== 32'h20) $display("FAIL jal_link: got %h want 20", alu_out_e); else passed++;
        checks++; if (reg_write_e !== 1'b1) $display("FAIL jal_rw: got %b want 1", reg_write_e); else passed++;
        drive(32'h03E00008, 32'h0, 32'h0, 32'h8, 32'h0); // jr $31
        checks++; if (dctl !== 9'h005) $display("FAIL jr_dctl: got %h want %h", dctl, 9'h005); else passed++;
        drive(32'h08000010, 32'h0, 32'h0, 32'h10, 32'h0); // j
        checks++; if (dctl !== 9'h004) $display("FAIL j_dctl: got %h want %h", dctl, 9'h004); else passed++;
    endtask

    task automatic test_mem_imm();
        drive(32'h8C240008, 32'h1000, 32'd0, 32'd8, 32'h0); // lw $4,8($1)
        checks++; if (dctl !== 9'h1C0) $display("FAIL lw_dctl: got %h want %h", dctl, 9'h1C0); else passed++;
        fall();
        checks++; if (alu_out_e !== 32'h1008) $display("FAIL lw_addr: got %h want 1008", alu_out_e); else passed++;
        checks++; if (ectl !== 4'b1110) $display("FAIL lw_ectl: got %b want 1110", ectl); else passed++;
        checks++; if (rt_addr_e !== 5'd4) $display("FAIL lw_rt_addr: got %0d want 4", rt_addr_e); else passed++;
        checks++; if (write_reg_addr_e !== 5'd4) $display("FAIL lw_wra: got %0d want 4", write_reg_addr_e); else passed++;
        drive(32'hAC450004, 32'h200, 32'hABCD, 32'd4, 32'h0); // sw $5,4($2)
        checks++; if (dctl !== 9'h020) $display("FAIL sw_dctl: got %h want %h", dctl, 9'h020); else passed++;
        fall();
        checks++; if (alu_out_e !== 32'h204) $display("FAIL sw_addr: got %h want 204", alu_out_e); else passed++;
        checks++; if (write_data_e !== 32'hABCD) $display("FAIL sw_wdata: got %h want ABCD", write_data_e); else passed++;
        checks++; if (ectl !== 4'b0001) $display("FAIL sw_ectl: got %b want 0001", ectl); else passed++;
        drive(32'h3023F0F0, 32'hFFFF00FF, 32'd0, 32'hFFFFF0F0, 32'h0); // andi $3,$1,0xF0F0
        fall();
        checks++; if (alu_out_e !== 32'h000000F0) $display("FAIL andi_zext: got %h want 000000F0", alu_out_e); else passed++;
        checks++; if (write_reg_addr_e !== 5'd3) $display("FAIL andi_wra: got %0d want 3", write_reg_addr_e); else passed++;
        drive(32'h2022FFFF, 32'd0, 32'd0, 32'hFFFFFFFF, 32'h0); // addi $2,$1,-1
        fall();
        checks++; if (alu_out_e !== 32'hFFFFFFFF) $display("FAIL addi_sext: got %h want FFFFFFFF", alu_out_e); else passed++;
    endtask

    task automatic test_bubble_invalid();
        drive(32'h8C240008, 32'h1000, 32'd0, 32'd8, 32'h0);
        ctrl_en = 1'b0; #1;
        checks++; if (dctl !== 9'h000) $display("FAIL bubble_dctl: got %h want 000", dctl); else passed++;
        fall();
        checks++; if (ectl !== 4'b0) $display("FAIL bubble_ectl: got %b want 0000", ectl); else passed++;
        ctrl_en = 1'b1;
        drive(32'hFFFFFFFF, 32'h0, 32'h0, 32'h0, 32'h0);
        checks++; if (dctl !== 9'h000) $display("FAIL halt_dctl: got %h want 000", dctl); else passed++;
        drive(32'h00000000, 32'h0, 32'h0, 32'h0, 32'h0);
        checks++; if (dctl !== 9'h000) $display("FAIL nop_dctl: got %h want 000", dctl); else passed++;
        drive(32'h3C000000, 32'h0, 32'h0, 32'h0, 32'h0);
        checks++; if (dctl !== 9'h000) $display("FAIL unk_dctl: got %h want 000", dctl); else passed++;
    endtask

    task automatic test_reset_midstream();
        drive(32'h8C240008, 32'h1000, 32'd0, 32'd8, 32'h40);
        fall();
        rst = 1'b1; #1;
        checks++; if (ectl !== 4'b0) $display("FAIL midrst_ectl: got %b want 0000", ectl); else passed++;
        checks++; if (alu_out_e !== 32'd0) $display("FAIL midrst_alu: got %h want 0", alu_out_e); else passed++;
        checks++; if (write_reg_addr_e !== 5'd0) $display("FAIL midrst_wra: got %0d want 0", write_reg_addr_e); else passed++;
        checks++; if (pc_branch_e !== 32'd0) $display("FAIL midrst_pcb: got %h want 0", pc_branch_e); else passed++;
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_alu_rtype();
        test_forward();
        test_shifts();
        test_branch();
        test_jump();
        test_mem_imm();
        test_bubble_invalid();
        test_reset_midstream();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
